// File: rtl/mem_responder.sv
// Single-port word memory behind a read/write request handshake with programmable wait states.
// A request presented in IDLE is accepted on the next edge; ready pulses WAIT_CYCLES edges later.
module mem_responder #(
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);

   localparam int         DEPTH    = 2 ** DEPTH_LOG2;
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                r_state, w_state_next;
   logic [3:0]            r_cnt, w_cnt_next;
   logic [31:0]           r_addr, r_wdata;
   logic                  r_write, r_both;
   logic                  r_err, r_rd_ok;
   logic [31:0]           r_mem [DEPTH];
   logic [31:0]           r_mem_dout;

   logic                  w_req, w_enter_resp, w_mem_we;
   logic [31:0]           w_op_addr, w_op_wdata;
   logic                  w_op_write, w_op_both, w_op_err;
   logic [DEPTH_LOG2-1:0] w_idx;

   // With zero wait states RESP is entered from IDLE, so the live inputs stand in for the latched copies.
   always_comb begin
      w_req        = mem_read | mem_write;
      w_op_addr    = (r_state == S_IDLE) ? addr  : r_addr;
      w_op_wdata   = (r_state == S_IDLE) ? wdata : r_wdata;
      w_op_write   = (r_state == S_IDLE) ? (mem_write & ~mem_read) : r_write;
      w_op_both    = (r_state == S_IDLE) ? (mem_write & mem_read)  : r_both;
      w_op_err     = w_op_both | (w_op_addr[1:0] != 2'b00)
                     | ((w_op_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
      w_idx        = w_op_addr[DEPTH_LOG2+1:2];
      w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP);
      w_mem_we     = w_enter_resp & w_op_write & ~w_op_err & rst;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_write <= 1'b0;
         r_both  <= 1'b0;
         r_err   <= 1'b0;
         r_rd_ok <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (r_state == S_IDLE && w_req) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_write <= mem_write & ~mem_read;
            r_both  <= mem_write & mem_read;
         end
         if (w_enter_resp) begin
            r_err   <= w_op_err;
            r_rd_ok <= ~w_op_write & ~w_op_err;
         end
      end
   end

   // An abort in WAIT takes priority over the counter reaching zero.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (WAIT_CYCLES == 0) begin
                  w_state_next = S_RESP;
               end else begin
                  w_state_next = S_WAIT;
                  w_cnt_next   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (!w_req) begin
               w_state_next = S_IDLE;
               w_cnt_next   = 4'd0;
            end else if (r_cnt == 4'd0) begin
               w_state_next = S_RESP;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         S_RESP:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_idx] <= w_op_wdata;
      end
      if (w_enter_resp) begin
         r_mem_dout <= r_mem[w_idx];
      end
   end

   always_comb begin
      ready = (r_state == S_RESP);
      busy  = (r_state != S_IDLE);
      err   = ready & r_err;
      rdata = (ready && r_rd_ok) ? r_mem_dout : 32'd0;
   end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: instance 0 runs with two wait states, instance 1 with none.
module tb_mem_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n [2];
   logic        rd    [2];
   logic        wr    [2];
   logic [31:0] a     [2];
   logic [31:0] wd    [2];
   logic [31:0] rdata [2];
   logic        ready [2];
   logic        err   [2];
   logic        busy  [2];

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u0 (
      .clk(clk), .rst(rst_n[0]), .mem_read(rd[0]), .mem_write(wr[0]),
      .addr(a[0]), .wdata(wd[0]), .rdata(rdata[0]), .ready(ready[0]),
      .err(err[0]), .busy(busy[0]));

   mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u1 (
      .clk(clk), .rst(rst_n[1]), .mem_read(rd[1]), .mem_write(wr[1]),
      .addr(a[1]), .wdata(wd[1]), .rdata(rdata[1]), .ready(ready[1]),
      .err(err[1]), .busy(busy[1]));

   function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %h, required %h", name, d, act, expv);
      end
   endfunction

   function automatic void mon(int d);
      exp_t e;
      if (ready[d]) begin
         if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            chk("unexpected_ready", d, 32'd1, 32'd0);
         end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("rdata", d, rdata[d], e.rdata);
            chk("err", d, {31'd0, err[d]}, {31'd0, e.err});
            chk("ready_cycle", d, cyc, e.cyc);
         end
      end else begin
         chk("err_without_ready", d, {31'd0, err[d]}, 32'd0);
      end
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) mon(d);
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: time=%0t, required finish earlier", $time);
      $fatal(1, "timeout");
   end

   task automatic idle(input int d);
      rd[d] = 1'b0;
      wr[d] = 1'b0;
   endtask

   task automatic issue(input int d, input bit r, input bit w, input logic [31:0] ad,
                        input logic [31:0] dat, input logic [31:0] er, input bit ee);
      exp_t e;
      rd[d] = r;
      wr[d] = w;
      a[d]  = ad;
      wd[d] = dat;
      e.rdata = er;
      e.err   = ee;
      e.cyc   = cyc + 1 + ((d == 0) ? 2 : 0);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic wait_ready(input int d);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (ready[d]) seen = 1'b1;
      end
      chk("ready_timeout", d, {31'd0, seen}, 32'd1);
      @(posedge clk); #1;
   endtask

   // Address and data are scrambled after acceptance; only the latched copies may matter.
   task automatic txn(input int d, input bit r, input bit w, input logic [31:0] ad,
                      input logic [31:0] dat, input logic [31:0] er, input bit ee);
      issue(d, r, w, ad, dat, er, ee);
      @(posedge clk); #1;
      chk("busy_after_accept", d, {31'd0, busy[d]}, 32'd1);
      a[d]  = ad ^ 32'hFFFF_FFFF;
      wd[d] = ~dat;
      wait_ready(d);
      idle(d);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0;
         idle(d);
         a[d]  = 32'd0;
         wd[d] = 32'd0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", d, {31'd0, ready[d]}, 32'd0);
         chk("rst_err", d, {31'd0, err[d]}, 32'd0);
         chk("rst_busy", d, {31'd0, busy[d]}, 32'd0);
         chk("rst_rdata", d, rdata[d], 32'd0);
      end
      @(posedge clk); #1;
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      txn(0, 0, 1, 32'h0,   32'h1111_1111, 32'h0, 0);
      txn(0, 0, 1, 32'h20,  32'h2222_2222, 32'h0, 0);
      txn(0, 0, 1, 32'h8,   32'h3333_3333, 32'h0, 0);
      txn(0, 0, 1, 32'h10,  32'hDEAD_BEEF, 32'h0, 0);
      txn(0, 1, 0, 32'h10,  32'h0, 32'hDEAD_BEEF, 0);
      txn(0, 1, 0, 32'h13,  32'h0, 32'h0, 1);
      txn(0, 1, 0, 32'h10,  32'h0, 32'hDEAD_BEEF, 0);
      txn(0, 0, 1, 32'h400, 32'h1, 32'h0, 1);
      txn(0, 1, 0, 32'h0,   32'h0, 32'h1111_1111, 0);
      txn(0, 1, 1, 32'h0,   32'h99, 32'h0, 1);
      txn(0, 1, 0, 32'h0,   32'h0, 32'h1111_1111, 0);

      // Abort: request dropped in the last wait cycle, so no response may follow.
      rd[0] = 1'b0; wr[0] = 1'b1; a[0] = 32'h20; wd[0] = 32'h55;
      @(posedge clk); #1;
      @(posedge clk); #1;
      idle(0);
      @(negedge clk);
      chk("busy_in_wait", 0, {31'd0, busy[0]}, 32'd1);
      @(posedge clk); #1;
      chk("busy_after_abort", 0, {31'd0, busy[0]}, 32'd0);
      @(posedge clk); #1;
      txn(0, 1, 0, 32'h20, 32'h0, 32'h2222_2222, 0);

      // Back-to-back: the read is held across ready, then becomes a write in the idle cycle.
      issue(0, 1, 0, 32'h0, 32'h0, 32'h1111_1111, 0);
      @(posedge clk); #1;
      wait_ready(0);
      issue(0, 0, 1, 32'h4, 32'h4444_4444, 32'h0, 0);
      @(posedge clk); #1;
      wait_ready(0);
      idle(0);
      txn(0, 1, 0, 32'h4, 32'h0, 32'h4444_4444, 0);

      // Reset in the middle of a write's wait phase.
      rd[0] = 1'b0; wr[0] = 1'b1; a[0] = 32'h8; wd[0] = 32'h0000_AAAA;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("busy_before_reset", 0, {31'd0, busy[0]}, 32'd1);
      rst_n[0] = 1'b0;
      #1;
      chk("midrst_ready", 0, {31'd0, ready[0]}, 32'd0);
      chk("midrst_busy", 0, {31'd0, busy[0]}, 32'd0);
      chk("midrst_err", 0, {31'd0, err[0]}, 32'd0);
      chk("midrst_rdata", 0, rdata[0], 32'd0);
      idle(0);
      repeat (2) @(posedge clk);
      #1;
      rst_n[0] = 1'b1;
      txn(0, 1, 0, 32'h8, 32'h0, 32'h3333_3333, 0);

      txn(1, 0, 1, 32'h8,   32'h1234_5678, 32'h0, 0);
      txn(1, 1, 0, 32'h8,   32'h0, 32'h1234_5678, 0);
      txn(1, 1, 0, 32'h2,   32'h0, 32'h0, 1);
      txn(1, 1, 1, 32'h8,   32'h0, 32'h0, 1);
      txn(1, 0, 1, 32'h800, 32'h7, 32'h0, 1);
      txn(1, 1, 0, 32'h8,   32'h0, 32'h1234_5678, 0);

      repeat (6) @(posedge clk);
      #1;
      chk("pending_dut0", 0, q0.size(), 32'd0);
      chk("pending_dut1", 1, q1.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
